// File: rtl/quad_step_decoder_pkg.sv
// Shared types and command codes for the quadrature step decoder and its downstream counter.
package quad_step_decoder_pkg;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_state_e;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DN   = 2'b10;

  // Next Gray code in the clockwise (up) direction.
  function automatic logic [1:0] fwd_of(input quad_state_e s);
    case (s)
      Q00:     fwd_of = 2'b01;
      Q01:     fwd_of = 2'b11;
      Q11:     fwd_of = 2'b10;
      default: fwd_of = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input quad_state_e s);
    case (s)
      Q00:     rev_of = 2'b10;
      Q10:     rev_of = 2'b11;
      Q11:     rev_of = 2'b01;
      default: rev_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/quad_step_decoder_sync_debounce.sv
// One encoder channel: 2-FF synchroniser followed by a stable-count debounce filter.
module sync_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw,
  output logic deb
);

  logic            sync_1;
  logic            sync_2;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      deb    <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == deb) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
        // Level held different for DEB_CYCLES consecutive cycles: accept it.
        deb <= sync_2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Rotary-encoder front end: debounced A/B channels drive a Gray-sequence
// direction FSM that emits registered up/down step commands.
//
//   state | meaning
//   Q00   | debounced {A,B} = 00
//   Q01   | debounced {A,B} = 01
//   Q11   | debounced {A,B} = 11
//   Q10   | debounced {A,B} = 10
module quad_step_decoder
  import quad_step_decoder_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       A_raw,
  input  logic       B_raw,
  input  logic       Dec_En,
  input  logic       Clr_Err,
  output logic [1:0] X,
  output logic       En,
  output logic       Err_Flag
);

  logic        a_deb;
  logic        b_deb;
  logic [1:0]  deb_ab;
  quad_state_e state_q;
  quad_state_e state_d;
  logic        step_up;
  logic        step_dn;
  logic        illegal;
  logic [1:0]  x_d;
  logic        en_d;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_a (
    .Clk (Clk),
    .Rst (Rst),
    .raw (A_raw),
    .deb (a_deb)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_b (
    .Clk (Clk),
    .Rst (Rst),
    .raw (B_raw),
    .deb (b_deb)
  );

  assign deb_ab = {a_deb, b_deb};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= Q00;
    else      state_q <= state_d;
  end

  // The FSM always tracks the debounced pair; Dec_En only gates the outputs.
  always_comb begin
    state_d = quad_state_e'(deb_ab);
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    if (deb_ab != state_q) begin
      if (deb_ab == fwd_of(state_q))      step_up = 1'b1;
      else if (deb_ab == rev_of(state_q)) step_dn = 1'b1;
      else                                illegal = 1'b1;
    end
    x_d  = CMD_HOLD;
    en_d = 1'b0;
    if (Dec_En && step_up) begin
      x_d  = CMD_UP;
      en_d = 1'b1;
    end else if (Dec_En && step_dn) begin
      x_d  = CMD_DN;
      en_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      X        <= CMD_HOLD;
      En       <= 1'b0;
      Err_Flag <= 1'b0;
    end else begin
      X  <= x_d;
      En <= en_d;
      if (illegal)      Err_Flag <= 1'b1;
      else if (Clr_Err) Err_Flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench: each driven encoder step pushes its expected command and due cycle.
module tb_quad_step_decoder;
  import quad_step_decoder_pkg::*;

  typedef struct {
    logic [1:0] x;
    int         due;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       A_raw;
  logic       B_raw;
  logic       Dec_En;
  logic       Clr_Err;
  logic [1:0] X;
  logic       En;
  logic       Err_Flag;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_on   = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  quad_step_decoder #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .A_raw    (A_raw),
    .B_raw    (B_raw),
    .Dec_En   (Dec_En),
    .Clr_Err  (Clr_Err),
    .X        (X),
    .En       (En),
    .Err_Flag (Err_Flag)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Called at posedge+2; holds the new raw levels for 'hold' cycles.
  task automatic set_ab(input logic a, input logic b, input bit push,
                        input logic [1:0] x, input int hold);
    A_raw = a;
    B_raw = b;
    if (push) sb.push_back('{x: x, due: cyc + 7});
    repeat (hold) @(posedge Clk);
    #2;
  endtask

  task automatic drain(input string tag);
    repeat (12) @(posedge Clk);
    #2;
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge Clk) begin
    if (Rst && mon_on) begin
      if (En) begin
        if (sb.size() == 0) begin
          check("spurious_en", 32'(En), 0);
        end else begin
          mon_e = sb.pop_front();
          check("step_x", 32'(X), 32'(mon_e.x));
          check("step_lat", 32'(cyc >= mon_e.due - 1 && cyc <= mon_e.due + 1), 1);
        end
      end else begin
        check("idle_x", 32'(X), 32'(CMD_HOLD));
      end
    end
  end

  initial begin
    Rst = 1'b0; A_raw = 1'b1; B_raw = 1'b1; Dec_En = 1'b1; Clr_Err = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("rst_x", 32'(X), 32'(CMD_HOLD));
      check("rst_en", 32'(En), 0);
      check("rst_err", 32'(Err_Flag), 0);
    end
    @(posedge Clk); #2;
    Rst = 1'b1;
    @(negedge Clk);
    check("rel_x", 32'(X), 32'(CMD_HOLD));
    check("rel_en", 32'(En), 0);
    check("rel_err", 32'(Err_Flag), 0);
    A_raw = 1'b0; B_raw = 1'b0;
    mon_on = 1'b1;
    @(posedge Clk); #2;
    drain("rel_idle");
    check("rel_err2", 32'(Err_Flag), 0);

    // Forward and reverse rotations
    set_ab(0, 1, 1, CMD_UP, 10);
    set_ab(1, 1, 1, CMD_UP, 10);
    set_ab(1, 0, 1, CMD_UP, 10);
    set_ab(0, 0, 1, CMD_UP, 10);
    drain("fwd_count");
    set_ab(1, 0, 1, CMD_DN, 10);
    set_ab(1, 1, 1, CMD_DN, 10);
    set_ab(0, 1, 1, CMD_DN, 10);
    set_ab(0, 0, 1, CMD_DN, 10);
    drain("rev_count");

    // Bounce on B, then a lone glitch on A
    for (int i = 0; i < 3; i++) begin
      set_ab(0, 1, 0, CMD_HOLD, 3);
      set_ab(0, 0, 0, CMD_HOLD, 3);
    end
    set_ab(0, 1, 1, CMD_UP, 12);
    drain("bounce_count");
    set_ab(1, 1, 0, CMD_HOLD, 3);
    set_ab(0, 1, 0, CMD_HOLD, 12);
    drain("glitch_count");
    set_ab(0, 0, 1, CMD_DN, 10);
    drain("back_to_00");
    check("no_err_yet", 32'(Err_Flag), 0);

    // Illegal double transition; Q11->Q10 afterwards proves the FSM resynced
    set_ab(1, 1, 0, CMD_HOLD, 12);
    check("illegal_err", 32'(Err_Flag), 1);
    set_ab(1, 0, 1, CMD_UP, 10);
    drain("resync_step");
    check("err_sticky", 32'(Err_Flag), 1);
    Clr_Err = 1'b1;
    @(posedge Clk); #2;
    Clr_Err = 1'b0;
    check("err_cleared", 32'(Err_Flag), 0);
    set_ab(0, 0, 1, CMD_UP, 10);
    drain("after_clear");

    // Gating: silent tracking, then one enabled step
    Dec_En = 1'b0;
    set_ab(0, 1, 0, CMD_HOLD, 10);
    set_ab(1, 1, 0, CMD_HOLD, 10);
    set_ab(1, 0, 0, CMD_HOLD, 10);
    Dec_En = 1'b1;
    set_ab(0, 0, 1, CMD_UP, 10);
    drain("gate_count");

    // Reset mid-phase at 01, then 11 is the first accepted pair
    set_ab(0, 1, 0, CMD_HOLD, 3);
    Rst = 1'b0;
    @(negedge Clk);
    check("mid_rst_x", 32'(X), 32'(CMD_HOLD));
    check("mid_rst_en", 32'(En), 0);
    @(posedge Clk); #2;
    Rst = 1'b1;
    set_ab(1, 1, 0, CMD_HOLD, 12);
    check("mid_rst_err", 32'(Err_Flag), 1);
    drain("mid_rst_nostep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
